jac_seq_ctrl: RTL and testbench
===============================

Name: jac_seq_ctrl

Overview:
- Instruction sequencer for the Jac1-8 8-bit core.
- Fetches 16-bit instructions from an external instruction memory, reads the internal register file and drives the combinational ALU_J.
- Writes results back, keeps the status flags and executes program-flow opcodes: GOTO, IFZ, IFNZ, IFEQ, IFST, IFGT.
- Owns PC, register file and flags; the ALU stays purely combinational.

Parameters:
- DataWidth, 8, register/ALU data width
- NumOpCodeBits, 5, opcode field width (same encoding as ALU_J)
- ParamBits, 8, immediate/param field width
- NumStatusBits, 3, ALU status width (bit0 Carry, bit1 Underflow, bit2 Zero)
- NumRegs, 8, register file depth (3-bit index)
- PcWidth, 8, program counter / imem address width

Ports:
- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  start/continue execution
- imem_req  out  1  fetch request
- imem_addr  out  PcWidth  fetch address (= pc)
- imem_ack  in  1  instruction valid this cycle
- imem_data  in  16  instruction word
- alu_opcode  out  NumOpCodeBits  to ALU_J opcode
- alu_op1  out  DataWidth  to ALU_J operand1
- alu_op2  out  DataWidth  to ALU_J operand2
- alu_param  out  ParamBits  to ALU_J param
- alu_result  in  DataWidth  from ALU_J result
- alu_status  in  NumStatusBits  from ALU_J status
- halted  out  1  HALT executed
- illegal  out  1  sticky: reserved opcode executed
- pc  out  PcWidth  current program counter
- flags  out  NumStatusBits  architectural flags
- dbg_addr  in  3  register debug read index
- dbg_data  out  DataWidth  R[dbg_addr], combinational

Behaviour:
- Instruction format: [15:11] opcode, [10:8] ra (dest/operand1), [7:0] param. rb = param[2:0].
- FSM states: IDLE, FETCH, EXEC, WB, HALT.
- Reset (sync): state IDLE; pc 0; R[0..7] 0; flags 0; imem_req 0; halted 0; illegal 0; alu_* outputs 0. Reset overrides everything, including an outstanding fetch, which is abandoned.
- IDLE: go to FETCH when run=1.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, latch imem_data into IR and go to EXEC. Otherwise stay (no timeout). imem_req is 0 in every other state.
- EXEC: alu_opcode=IR.opcode, alu_op1=R[ra], alu_op2=R[rb], alu_param=param. Latch alu_result/alu_status into internal regs and go to WB. In all non-EXEC states alu_opcode=0 (NOP), operands 0.
- Compare ops IFEQ/IFST/IFGT: the controller drives alu_opcode=SUB (0x02) in EXEC instead of the branch code.
- WB, by opcode:
  - ADD..SHR (0x01-0x08): R[ra]<=result; flags<=status; pc<=pc+1.
  - NOP (0x00): pc+1 only.
  - VAL (0x09): R[ra]<=param; flags unchanged; pc+1.
  - GOTO (0x10): pc<=param.
  - IFZ/IFNZ: pc+1 if flags[2] is 1/0 respectively, else pc+2 (skip next instruction).
  - IFEQ/IFST/IFGT: condition from latched SUB status: EQ=Z, ST=U, GT=!Z&!U. pc+1 if true, else pc+2. Registers and flags unchanged.
  - HALT (0x17): halted<=1; go to HALT.
  - Other reserved codes: act as NOP; illegal<=1 (sticky until reset).
- After WB: FETCH if run=1, else IDLE. run dropping mid-instruction never aborts it.
- HALT state: absorbing until reset; run ignored.
- PC arithmetic is modulo 2^PcWidth: pc+1 from 255 gives 0; pc+2 from 254 gives 0, from 255 gives 1.
- Register writes with ra=rb are legal; R[ra] is updated only in WB.
- Latency: 3 cycles per instruction when imem_ack arrives in the first FETCH cycle; +1 per wait cycle.

Test Plan:
- Reset, run=1, imem: 0x0 VAL R1,5; 0x1 VAL R2,3; 0x2 ADD R1,R2 -> R1=8, flags=000, pc=3 after 9 cycles (ack immediate).
- R1=200, R2=100, ADD R1,R2 -> R1=44, flags=001 (carry). Then SUB with R1=3, R2=3 -> R1=0, flags=100.
- R1=3, R2=5, IFST R1,R2 at pc=10 -> pc=11. IFGT at pc=10 -> pc=12. IFEQ with R1=R2=7 -> pc=11, R1 and flags unchanged.
- GOTO 0xFE then IFZ with Z=0 at 0xFE -> pc wraps to 0x00. HALT (0xB800) -> halted=1, imem_req stays 0 thereafter.
- imem_ack delayed 4 cycles; reset asserted during the 2nd wait cycle -> next cycle state IDLE, pc=0, imem_req=0, registers 0.
- Opcode 0x0A executed -> illegal=1, pc+1, registers/flags unchanged. Drop run during EXEC -> WB completes, then IDLE.

Source files
------------

// File: rtl/jac_seq_ctrl.sv
// ----------------------------------------------------------------------------
// jac_seq_ctrl -- instruction sequencer for the Jac1-8 8-bit core.
//
// Fetches 16-bit instructions from an external instruction memory, reads the
// internal register file, drives the purely combinational ALU_J, writes the
// result back and maintains the architectural status flags. Program-flow
// opcodes (GOTO, IFZ, IFNZ, IFEQ, IFST, IFGT) are resolved here.
//
// Instruction word: [15:11] opcode, [10:8] ra (dest / operand1), [7:0] param.
// The second source register rb is param[2:0].
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   run                 start / continue execution
//   imem_req/addr       fetch request and address (address is always pc)
//   imem_ack/data       instruction valid strobe and instruction word
//   alu_opcode/op1/op2  ALU_J operands, driven only in EXEC (NOP/0 otherwise)
//   alu_param           ALU_J param field
//   alu_result/status   ALU_J outputs, captured at the end of EXEC
//   halted              HALT has been executed
//   illegal             sticky: a reserved opcode has been executed
//   pc, flags           program counter and architectural flags {Z,U,C}
//   dbg_addr/dbg_data   combinational register-file read port
// ----------------------------------------------------------------------------
module jac_seq_ctrl #(
    parameter int DataWidth     = 8,
    parameter int NumOpCodeBits = 5,
    parameter int ParamBits     = 8,
    parameter int NumStatusBits = 3,
    parameter int NumRegs       = 8,
    parameter int PcWidth       = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run,
    output logic                     imem_req,
    output logic [PcWidth-1:0]       imem_addr,
    input  logic                     imem_ack,
    input  logic [15:0]              imem_data,
    output logic [NumOpCodeBits-1:0] alu_opcode,
    output logic [DataWidth-1:0]     alu_op1,
    output logic [DataWidth-1:0]     alu_op2,
    output logic [ParamBits-1:0]     alu_param,
    input  logic [DataWidth-1:0]     alu_result,
    input  logic [NumStatusBits-1:0] alu_status,
    output logic                     halted,
    output logic                     illegal,
    output logic [PcWidth-1:0]       pc,
    output logic [NumStatusBits-1:0] flags,
    input  logic [2:0]               dbg_addr,
    output logic [DataWidth-1:0]     dbg_data
);

    // Opcode map (shared with ALU_J for 0x00-0x09)
    localparam logic [NumOpCodeBits-1:0] OP_NOP  = NumOpCodeBits'(8'h00);
    localparam logic [NumOpCodeBits-1:0] OP_ADD  = NumOpCodeBits'(8'h01);
    localparam logic [NumOpCodeBits-1:0] OP_SUB  = NumOpCodeBits'(8'h02);
    localparam logic [NumOpCodeBits-1:0] OP_SHR  = NumOpCodeBits'(8'h08);
    localparam logic [NumOpCodeBits-1:0] OP_VAL  = NumOpCodeBits'(8'h09);
    localparam logic [NumOpCodeBits-1:0] OP_GOTO = NumOpCodeBits'(8'h10);
    localparam logic [NumOpCodeBits-1:0] OP_IFZ  = NumOpCodeBits'(8'h11);
    localparam logic [NumOpCodeBits-1:0] OP_IFNZ = NumOpCodeBits'(8'h12);
    localparam logic [NumOpCodeBits-1:0] OP_IFEQ = NumOpCodeBits'(8'h13);
    localparam logic [NumOpCodeBits-1:0] OP_IFST = NumOpCodeBits'(8'h14);
    localparam logic [NumOpCodeBits-1:0] OP_IFGT = NumOpCodeBits'(8'h15);
    localparam logic [NumOpCodeBits-1:0] OP_HALT = NumOpCodeBits'(8'h17);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [15:0]              ir;
    logic [DataWidth-1:0]     regs [NumRegs];
    logic [DataWidth-1:0]     res_q;
    logic [NumStatusBits-1:0] stat_q;

    // Decoded instruction fields
    logic [NumOpCodeBits-1:0] op_f;
    logic [2:0]               ra_f;
    logic [2:0]               rb_f;
    logic [ParamBits-1:0]     param_f;

    assign op_f    = ir[15:11];
    assign ra_f    = ir[10:8];
    assign param_f = ir[7:0];
    assign rb_f    = param_f[2:0];

    // Write-back decisions
    logic [PcWidth-1:0]   pc_plus1, pc_plus2, pc_nxt;
    logic                 reg_we, flag_we, set_illegal, set_halt;
    logic [DataWidth-1:0] reg_wd;

    assign pc_plus1 = pc + PcWidth'(1);
    assign pc_plus2 = pc + PcWidth'(2);

    // Compare branches execute a SUB on the ALU so their outcome comes from
    // the status captured in EXEC; IFZ/IFNZ test the architectural Z flag.
    function automatic logic cond_true(
        input logic [NumOpCodeBits-1:0] op,
        input logic [NumStatusBits-1:0] arch_flags,
        input logic [NumStatusBits-1:0] sub_st
    );
        logic c;
        c = 1'b1;
        case (op)
            OP_IFZ:  c = arch_flags[2];
            OP_IFNZ: c = !arch_flags[2];
            OP_IFEQ: c = sub_st[2];
            OP_IFST: c = sub_st[1];
            OP_IFGT: c = !sub_st[2] && !sub_st[1];
            default: c = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic is_compare(input logic [NumOpCodeBits-1:0] op);
        return (op == OP_IFEQ) || (op == OP_IFST) || (op == OP_IFGT);
    endfunction

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run) state_nxt = S_FETCH;
            S_FETCH: if (imem_ack) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB: begin
                if (op_f == OP_HALT) state_nxt = S_HALT;
                else if (run)        state_nxt = S_FETCH;
                else                 state_nxt = S_IDLE;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Memory / ALU drive: only FETCH requests, only EXEC presents operands
    always_comb begin
        imem_req   = (state == S_FETCH);
        imem_addr  = pc;
        alu_opcode = OP_NOP;
        alu_op1    = '0;
        alu_op2    = '0;
        alu_param  = '0;
        if (state == S_EXEC) begin
            alu_opcode = is_compare(op_f) ? OP_SUB : op_f;
            alu_op1    = regs[ra_f];
            alu_op2    = regs[rb_f];
            alu_param  = param_f;
        end
    end

    // Write-back decode
    always_comb begin
        pc_nxt      = pc_plus1;
        reg_we      = 1'b0;
        reg_wd      = res_q;
        flag_we     = 1'b0;
        set_illegal = 1'b0;
        set_halt    = 1'b0;
        case (op_f)
            OP_NOP: ;
            OP_VAL: begin
                reg_we = 1'b1;
                reg_wd = DataWidth'(param_f);
            end
            OP_GOTO: pc_nxt = PcWidth'(param_f);
            OP_IFZ, OP_IFNZ, OP_IFEQ, OP_IFST, OP_IFGT:
                pc_nxt = cond_true(op_f, flags, stat_q) ? pc_plus1 : pc_plus2;
            OP_HALT: begin
                set_halt = 1'b1;
                pc_nxt   = pc;
            end
            default: begin
                if (op_f >= OP_ADD && op_f <= OP_SHR) begin
                    reg_we  = 1'b1;
                    flag_we = 1'b1;
                end else begin
                    set_illegal = 1'b1;
                end
            end
        endcase
    end

    // State, architectural registers and capture registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            flags   <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            ir      <= '0;
            res_q   <= '0;
            stat_q  <= '0;
            for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && imem_ack) ir <= imem_data;
            if (state == S_EXEC) begin
                res_q  <= alu_result;
                stat_q <= alu_status;
            end
            if (state == S_WB) begin
                pc <= pc_nxt;
                if (reg_we)      regs[ra_f] <= reg_wd;
                if (flag_we)     flags      <= stat_q;
                if (set_illegal) illegal    <= 1'b1;
                if (set_halt)    halted     <= 1'b1;
            end
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_jac_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_jac_seq_ctrl -- self-checking bench for jac_seq_ctrl.
// Provides an instruction memory, a behavioural ALU_J and an instruction-level
// reference model of the Jac1-8 architecture; runs directed programs followed
// by randomized programs with random fetch latency and run drops.
// ----------------------------------------------------------------------------
module tb_jac_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic [4:0]  alu_opcode;
    logic [7:0]  alu_op1, alu_op2, alu_param, alu_result;
    logic [2:0]  alu_status;
    logic        halted, illegal;
    logic [7:0]  pc;
    logic [2:0]  flags;
    logic [2:0]  dbg_addr = 3'd0;
    logic [7:0]  dbg_data;

    int total = 0;
    int bad = 0;

    jac_seq_ctrl dut (
        .clock(clock), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_param(alu_param), .alu_result(alu_result), .alu_status(alu_status),
        .halted(halted), .illegal(illegal), .pc(pc), .flags(flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #10 clock = ~clock;

    // Behavioural ALU_J: returns {Z, U, C, result}
    function automatic logic [10:0] alu_f(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] p);
        logic [8:0] t;
        logic [7:0] r;
        logic c, u, z;
        t = 9'd0; r = 8'd0; c = 1'b0; u = 1'b0;
        case (op)
            5'h01: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; end
            5'h02: begin r = a - b; u = (a < b); end
            5'h03: r = a & b;
            5'h04: r = a | b;
            5'h05: r = a ^ b;
            5'h06: r = ~a;
            5'h07: begin r = {a[6:0], 1'b0}; c = a[7]; end
            5'h08: begin r = {1'b0, a[7:1]}; c = a[0]; end
            5'h09: r = p;
            default: r = 8'd0;
        endcase
        z = (op >= 5'h01) && (op <= 5'h08) && (r == 8'd0);
        return {z, u, c, r};
    endfunction

    assign {alu_status, alu_result} = alu_f(alu_opcode, alu_op1, alu_op2, alu_param);

    logic [15:0] mem [256];

    function automatic logic [15:0] ins(input int op, input int ra, input int p);
        return 16'((op << 11) | (ra << 8) | (p & 255));
    endfunction

    // Reference architectural state
    logic [7:0] m_pc;
    logic [7:0] m_r [8];
    logic [2:0] m_flags;
    logic       m_halt, m_ill;
    logic [7:0] d_r [8];

    task automatic model_reset();
        m_pc = 8'd0; m_flags = 3'd0; m_halt = 1'b0; m_ill = 1'b0;
        for (int i = 0; i < 8; i++) m_r[i] = 8'd0;
    endtask

    // One instruction at architectural level
    task automatic model_exec(input logic [15:0] w);
        logic [4:0]  op;
        logic [2:0]  ra, rb;
        logic [7:0]  p, a, b;
        logic [10:0] v;
        op = w[15:11]; ra = w[10:8]; p = w[7:0]; rb = p[2:0];
        a = m_r[ra]; b = m_r[rb];
        case (op)
            5'h00: m_pc = m_pc + 8'd1;
            5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08: begin
                v = alu_f(op, a, b, p);
                m_r[ra] = v[7:0]; m_flags = v[10:8]; m_pc = m_pc + 8'd1;
            end
            5'h09: begin m_r[ra] = p; m_pc = m_pc + 8'd1; end
            5'h10: m_pc = p;
            5'h11: m_pc = m_pc + (m_flags[2] ? 8'd1 : 8'd2);
            5'h12: m_pc = m_pc + (!m_flags[2] ? 8'd1 : 8'd2);
            5'h13: m_pc = m_pc + ((a == b) ? 8'd1 : 8'd2);
            5'h14: m_pc = m_pc + ((a < b) ? 8'd1 : 8'd2);
            5'h15: m_pc = m_pc + ((a > b) ? 8'd1 : 8'd2);
            5'h17: m_halt = 1'b1;
            default: begin m_ill = 1'b1; m_pc = m_pc + 8'd1; end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare all visible architectural state; register reads take 8 x 1ns
    task automatic check_arch(input string where);
        check({where, "_pc"}, pc, m_pc);
        check({where, "_flags"}, flags, m_flags);
        check({where, "_halted"}, halted, m_halt);
        check({where, "_illegal"}, illegal, m_ill);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            d_r[i] = dbg_data;
            check({where, "_reg"}, dbg_data, m_r[i]);
        end
    endtask

    // Execute one instruction with dly wait cycles before the ack
    task automatic step(input int dly, input bit drop, output bit ok);
        logic [15:0] w;
        logic [4:0]  o;
        int n;
        ok = 1'b1;
        n = 0;
        while (!imem_req && n < 20) begin @(negedge clock); n++; end
        if (!imem_req) begin
            check("fetch_timeout", 0, 1);
            ok = 1'b0;
            return;
        end
        check("imem_addr", imem_addr, m_pc);
        for (int i = 0; i < dly; i++) begin
            @(negedge clock);
            check("fetch_hold", imem_req, 1);
        end
        w = mem[m_pc];
        o = w[15:11];
        imem_ack = 1'b1; imem_data = w;
        @(negedge clock);
        imem_ack = 1'b0; imem_data = 16'($urandom);
        check("exec_op", alu_opcode, (o == 5'h13 || o == 5'h14 || o == 5'h15) ? 5'h02 : o);
        check("exec_op1", alu_op1, m_r[w[10:8]]);
        check("exec_op2", alu_op2, m_r[w[2:0]]);
        check("exec_param", alu_param, w[7:0]);
        check("exec_req", imem_req, 0);
        if (drop) run = 1'b0;
        @(negedge clock);
        check("wb_op", alu_opcode, 0);
        check("wb_req", imem_req, 0);
        model_exec(w);
        @(negedge clock);
        check("next_req", imem_req, run && !m_halt);
        check_arch("post");
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ack = 1'b0;
        repeat (3) @(negedge clock);
        model_reset();
        check("rst_req", imem_req, 0);
        check("rst_aluop", alu_opcode, 0);
        check("rst_op1", alu_op1, 0);
        check("rst_op2", alu_op2, 0);
        check("rst_param", alu_param, 0);
        check_arch("rst");
        reset = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        logic [7:0]  pb;
        logic [15:0] w;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]    = ins(5'h09, 1, 5);
        mem[1]    = ins(5'h09, 2, 3);
        mem[2]    = ins(5'h01, 1, 2);
        mem[3]    = ins(5'h09, 1, 200);
        mem[4]    = ins(5'h09, 2, 100);
        mem[5]    = ins(5'h01, 1, 2);
        mem[6]    = ins(5'h09, 1, 3);
        mem[7]    = ins(5'h09, 2, 3);
        mem[8]    = ins(5'h02, 1, 2);
        mem[9]    = ins(5'h09, 1, 3);
        mem[10]   = ins(5'h09, 2, 5);
        mem[11]   = ins(5'h10, 0, 20);
        mem[20]   = ins(5'h14, 1, 2);
        mem[21]   = ins(5'h15, 1, 2);
        mem[23]   = ins(5'h09, 3, 7);
        mem[24]   = ins(5'h09, 4, 7);
        mem[25]   = ins(5'h13, 3, 4);
        mem[26]   = ins(5'h01, 1, 2);
        mem[27]   = ins(5'h10, 0, 8'hFE);
        mem[8'hFE] = ins(5'h11, 0, 0);

        do_reset();
        run = 1'b1;

        // Directed program: arithmetic, compares, GOTO and PC wrap
        for (int k = 0; k < 21; k++) begin
            pb = m_pc;
            step(k % 3, 1'b0, ok);
            if (!ok) break;
            case (pb)
                8'd2:   begin check("tp_add_r1", d_r[1], 8);  check("tp_add_fl", flags, 0);
                              check("tp_add_pc", pc, 3); end
                8'd5:   begin check("tp_carry_r1", d_r[1], 44); check("tp_carry_fl", flags, 3'b001); end
                8'd8:   begin check("tp_sub_r1", d_r[1], 0);  check("tp_sub_fl", flags, 3'b100); end
                8'd20:  check("tp_ifst_pc", pc, 21);
                8'd21:  check("tp_ifgt_pc", pc, 23);
                8'd25:  begin check("tp_ifeq_pc", pc, 26); check("tp_ifeq_fl", flags, 3'b100);
                              check("tp_ifeq_r3", d_r[3], 7); end
                8'hFE:  check("tp_wrap_pc", pc, 0);
                default: ;
            endcase
        end

        // Reset arriving during the second wait cycle of a fetch
        check("rw_req_before", imem_req, 1);
        @(negedge clock);
        check("rw_req_wait1", imem_req, 1);
        reset = 1'b1;
        @(negedge clock);
        model_reset();
        check("rw_req", imem_req, 0);
        check_arch("rw");
        @(negedge clock);
        check("rw_req_hold", imem_req, 0);

        // Reserved opcode, run drop during EXEC, HALT
        mem[0] = ins(5'h09, 5, 9);
        mem[1] = ins(5'h0A, 5, 5);
        mem[2] = ins(5'h09, 6, 1);
        mem[3] = 16'hB800;
        reset = 1'b0;
        step(0, 1'b0, ok);
        step(1, 1'b0, ok);
        check("tp_illegal", illegal, 1);
        check("tp_illegal_r5", d_r[5], 9);
        step(0, 1'b1, ok);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("idle_req", imem_req, 0);
            check("idle_pc", pc, 3);
        end
        run = 1'b1;
        step(2, 1'b0, ok);
        check("tp_halted", halted, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("halt_req", imem_req, 0);
            check("halt_pc", pc, 3);
        end

        // Randomized programs
        do_reset();
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:11] == 5'h17) w[15:11] = 5'h09;
            mem[i] = w;
        end
        run = 1'b1;
        for (int k = 0; k < 300; k++) begin
            step(int'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), ok);
            if (!ok) break;
            if (!run) run = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
